// File: rtl/elevator_floor_controller.sv
// elevator_floor_controller: SCAN-ordered car controller that latches floor calls and drives a 3-bit floor code.
module elevator_floor_controller #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req,
  output logic                  floor_a2,
  output logic                  floor_a1,
  output logic                  floor_a0,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);
  typedef enum logic [1:0] {IDLE, MOVING_UP, MOVING_DOWN, DOOR_OPEN} state_t;
  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  state_t state, state_n;
  logic [2:0] floor, floor_n, nf, fr;
  logic [NUM_FLOORS-1:0] pending_n, eff, clear_mask;
  logic [TW-1:0] ttmr, ttmr_n;
  logic [DW-1:0] dtmr, dtmr_n;
  logic last_up, last_up_n, above, below, t_tc, moving;
  assign {floor_a2, floor_a1, floor_a0} = floor;
  assign moving_up   = state == MOVING_UP;
  assign moving_down = state == MOVING_DOWN;
  assign door_open   = state == DOOR_OPEN;
  assign moving      = moving_up || moving_down;
  assign t_tc        = ttmr == TW'(TRAVEL_CYCLES - 1);
  assign nf          = moving_down ? floor - 3'd1 : floor + 3'd1;
  // calls ahead are judged from the floor the car is about to occupy
  assign fr          = (moving && t_tc) ? nf : floor;
  assign eff         = pending | req;
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above = above | (eff[i] & (i > int'(fr)));
      below = below | (eff[i] & (i < int'(fr)));
    end
  end
  always_comb begin
    state_n    = state;
    floor_n    = floor;
    ttmr_n     = '0;
    dtmr_n     = '0;
    last_up_n  = last_up;
    clear_mask = '0;
    case (state)
      IDLE: begin
        if (eff[floor]) begin
          state_n           = DOOR_OPEN;
          clear_mask[floor] = 1'b1;
        end else if (above && (last_up || !below)) state_n = MOVING_UP;
        else if (below) state_n = MOVING_DOWN;
      end
      MOVING_UP, MOVING_DOWN: begin
        if (!t_tc) ttmr_n = ttmr + 1'b1;
        else begin
          floor_n   = nf;
          last_up_n = moving_up;
          if (eff[nf]) begin
            state_n        = DOOR_OPEN;
            clear_mask[nf] = 1'b1;
          end else if (!(moving_up ? above : below)) state_n = IDLE;
        end
      end
      DOOR_OPEN: begin
        // a call at the open floor is absorbed and holds the door longer
        clear_mask[floor] = 1'b1;
        if (req[floor]) dtmr_n = '0;
        else if (dtmr == DW'(DOOR_CYCLES - 1)) state_n = IDLE;
        else dtmr_n = dtmr + 1'b1;
      end
    endcase
    pending_n = eff & ~clear_mask;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      floor   <= '0;
      pending <= '0;
      ttmr    <= '0;
      dtmr    <= '0;
      last_up <= 1'b1;
    end else begin
      state   <= state_n;
      floor   <= floor_n;
      pending <= pending_n;
      ttmr    <= ttmr_n;
      dtmr    <= dtmr_n;
      last_up <= last_up_n;
    end
  end
endmodule

// File: tb/tb_elevator_floor_controller.sv
// tb_elevator_floor_controller: directed scenarios with hand-computed floor/status timing (TRAVEL=4, DOOR=6).
module tb_elevator_floor_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = '0;
  logic floor_a2, floor_a1, floor_a0, moving_up, moving_down, door_open;
  logic [7:0] pending;
  logic [2:0] fc;
  int n_vec = 0;
  int n_err = 0;
  assign fc = {floor_a2, floor_a1, floor_a0};
  elevator_floor_controller #(.NUM_FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .floor_a2(floor_a2), .floor_a1(floor_a1), .floor_a0(floor_a0),
    .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open),
    .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    wait_n(2);
    rst_n = 1'b1;
  endtask
  function automatic logic [2:0] st();
    return {moving_up, moving_down, door_open};
  endfunction
  initial begin
    // single call above: travel to 3, door, then idle
    do_reset();
    check("rst_floor", fc, 0);
    check("rst_status", st(), 0);
    check("rst_pending", pending, 0);
    req = 8'h08; tick(); req = '0;
    check("s1_up", st(), 3'b100);
    check("s1_pend", pending, 8'h08);
    wait_n(3);
    check("s1_f0_hold", fc, 0);
    tick();
    check("s1_f1", fc, 1);
    wait_n(4);
    check("s1_f2", fc, 2);
    wait_n(4);
    check("s1_f3", fc, 3);
    check("s1_door", st(), 3'b001);
    check("s1_pclr", pending, 0);
    wait_n(5);
    check("s1_door_last", st(), 3'b001);
    tick();
    check("s1_idle", st(), 0);
    check("s1_idle_floor", fc, 3);
    // call at the current floor while idle
    do_reset();
    req = 8'h01; tick(); req = '0;
    check("s2_door", st(), 3'b001);
    check("s2_pend", pending, 0);
    wait_n(5);
    check("s2_door_last", st(), 3'b001);
    check("s2_floor", fc, 0);
    tick();
    check("s2_idle", st(), 0);
    // intermediate call picked up on the way
    do_reset();
    req = 8'h20; tick(); req = '0;
    check("s3_up", st(), 3'b100);
    wait_n(4);
    check("s3_f1", fc, 1);
    tick();
    req = 8'h04; tick(); req = '0;
    check("s3_pend_both", pending, 8'h24);
    wait_n(2);
    check("s3_f2", fc, 2);
    check("s3_door2", st(), 3'b001);
    check("s3_pend20", pending, 8'h20);
    wait_n(6);
    check("s3_idle2", st(), 0);
    tick();
    check("s3_resume", st(), 3'b100);
    wait_n(12);
    check("s3_f5", fc, 5);
    check("s3_door5", st(), 3'b001);
    check("s3_pclr", pending, 0);
    // SCAN ordering: keep going up, then reverse
    do_reset();
    req = 8'h10; tick(); req = '0;
    wait_n(16);
    check("s4_f4", fc, 4);
    check("s4_door4", st(), 3'b001);
    wait_n(6);
    check("s4_idle4", st(), 0);
    req = 8'h42; tick(); req = '0;
    check("s4_up_first", st(), 3'b100);
    check("s4_pend42", pending, 8'h42);
    wait_n(8);
    check("s4_f6", fc, 6);
    check("s4_door6", st(), 3'b001);
    check("s4_pend02", pending, 8'h02);
    wait_n(6);
    check("s4_idle6", st(), 0);
    tick();
    check("s4_down", st(), 3'b010);
    wait_n(20);
    check("s4_f1", fc, 1);
    check("s4_door1", st(), 3'b001);
    check("s4_pclr", pending, 0);
    wait_n(6);
    req = 8'h81; tick(); req = '0;
    check("s4_lastdir_down", st(), 3'b010);
    check("s4_pend81", pending, 8'h81);
    // door hold extended by a call at the open floor
    do_reset();
    req = 8'h04; tick(); req = '0;
    wait_n(8);
    check("s5_f2", fc, 2);
    check("s5_door", st(), 3'b001);
    wait_n(4);
    req = 8'h04; tick(); req = '0;
    check("s5_pend_none", pending, 0);
    check("s5_door_held", st(), 3'b001);
    wait_n(5);
    check("s5_door_ext", st(), 3'b001);
    tick();
    check("s5_idle", st(), 0);
    check("s5_pend_end", pending, 0);
    // asynchronous reset mid-travel
    do_reset();
    req = 8'h80; tick(); req = '0;
    wait_n(12);
    check("s6_f3", fc, 3);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_floor", fc, 0);
    check("s6_async_status", st(), 0);
    check("s6_async_pend", pending, 0);
    #3 rst_n = 1'b1;
    wait_n(3);
    check("s6_post_floor", fc, 0);
    check("s6_post_status", st(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
